uart_tx_ctrl: RTL and testbench

Control unit for the UART transmit path. It accepts one byte per request from the host side. It then sequences an external transmit shift register and serial-line mux through start, data, optional parity, and stop bit periods. Baud timing and bit counting are internal. This is the transmit-side counterpart of the receive control unit and sits between the host write port and the tx shift register / line driver.

---
 rtl/uart_tx_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit control, sequencing start, data, optional
// parity (macro UART_TX_PARITY_EN) and stop bit periods of one frame.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_req,
    input  logic       tx_abort,
    output logic       tx_ready,
    output logic       load_sr,
    output logic       shift_sr,
    output logic [1:0] line_sel,
    output logic       tx_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_MAX = BW'(DATA_BITS - 1);

    localparam logic [1:0] LS_MARK  = 2'd0;
    localparam logic [1:0] LS_START = 2'd1;
    localparam logic [1:0] LS_DATA  = 2'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [1:0] LS_PAR   = 2'd3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [BW-1:0]   bitcnt_q;
    logic [1:0]      line_sel_q;

    logic in_idle;
    logic bit_end;
    logic last_bit;
    logic abort_act;

    // Decode handshake, pulse and line outputs from state and inputs
    always_comb begin
        in_idle   = (state_q == S_IDLE);
        bit_end   = (timer_q == T_MAX);
        last_bit  = (bitcnt_q == B_MAX);
        abort_act = ~in_idle & tx_abort;
        tx_ready  = in_idle & ~tx_abort & ~rst;
        load_sr   = tx_ready & tx_req;
        shift_sr  = (state_q == S_DATA) & bit_end & ~tx_abort;
        tx_done   = (state_q == S_STOP) & bit_end & ~tx_abort;
        line_sel  = abort_act ? LS_MARK : line_sel_q;
    end

    // Frame sequencer: state, bit timer, bit counter and line select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            line_sel_q <= LS_MARK;
        end else if (abort_act) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            line_sel_q <= LS_MARK;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    timer_q  <= '0;
                    bitcnt_q <= '0;
                    if (load_sr) begin
                        state_q    <= S_START;
                        line_sel_q <= LS_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q    <= S_DATA;
                        timer_q    <= '0;
                        line_sel_q <= LS_DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer_q <= '0;
                        if (last_bit) begin
                            bitcnt_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q    <= S_PARITY;
                            line_sel_q <= LS_PAR;
`else
                            state_q    <= S_STOP;
                            line_sel_q <= LS_MARK;
`endif
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state_q    <= S_STOP;
                        timer_q    <= '0;
                        line_sel_q <= LS_MARK;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        state_q    <= S_IDLE;
                        timer_q    <= '0;
                        line_sel_q <= LS_MARK;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    timer_q    <= '0;
                    bitcnt_q   <= '0;
                    line_sel_q <= LS_MARK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl; expected pulse and
// line-select events are queued by stimulus and matched by a monitor.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam int C = 2;
    localparam int P = 1;
`else
    localparam int C = 10;
    localparam int P = 0;
`endif
    localparam int D  = 8;
    localparam int FR = C * (D + 2 + P);

    localparam int K_LOAD  = 0;
    localparam int K_SHIFT = 1;
    localparam int K_DONE  = 2;
    localparam int K_LSEL  = 3;

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       tx_req;
    logic       tx_abort;
    logic       tx_ready;
    logic       load_sr;
    logic       shift_sr;
    logic [1:0] line_sel;
    logic       tx_done;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];
    logic [1:0] prev_ls = 2'd0;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(C),
        .DATA_BITS(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_req(tx_req),
        .tx_abort(tx_abort),
        .tx_ready(tx_ready),
        .load_sr(load_sr),
        .shift_sr(shift_sr),
        .line_sel(line_sel),
        .tx_done(tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_LOAD:  return "load_sr";
            K_SHIFT: return "shift_sr";
            K_DONE:  return "tx_done";
            default: return "line_sel";
        endcase
    endfunction

    task automatic push(int c, int k, int v);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Expected events of a complete frame accepted in cycle l
    task automatic push_frame(int l, bit no_done);
        push(l, K_LOAD, 1);
        push(l + 1, K_LSEL, 1);
        push(l + 1 + C, K_LSEL, 2);
        for (int k = 0; k < D; k++)
            push(l + C * (k + 2), K_SHIFT, 1);
        if (P == 1)
            push(l + 1 + C * (D + 1), K_LSEL, 3);
        push(l + 1 + C * (D + 1 + P), K_LSEL, 0);
        if (!no_done)
            push(l + FR, K_DONE, 1);
    endtask

    task automatic ev_check(int k, int v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected %s=%0d at cycle %0d, none required",
                     kname(k), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.val != v) begin
                n_bad++;
                $display("FAIL event: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                         kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every pulse and line_sel change is matched to the queue
    always @(negedge clk) begin
        if (load_sr === 1'b1)  ev_check(K_LOAD, 1);
        if (shift_sr === 1'b1) ev_check(K_SHIFT, 1);
        if (tx_done === 1'b1)  ev_check(K_DONE, 1);
        if (line_sel !== prev_ls) begin
            ev_check(K_LSEL, int'(line_sel));
            prev_ls = line_sel;
        end
    end

    task automatic chk(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_req();
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    int l;
    int l2;
    int a;
    int r;

    initial begin
        rst      = 1'b1;
        tx_req   = 1'b1;
        tx_abort = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_ready", tx_ready, 0);
        chk("rst_load", load_sr, 0);
        chk("rst_lsel", line_sel, 0);
        chk("rst_shift", shift_sr, 0);
        chk("rst_done", tx_done, 0);
        tx_req = 1'b0;
        rst    = 1'b0;
        #1;
        chk("idle_ready", tx_ready, 1);

        // single frame
        tick();
        l = cyc;
        push_frame(l, 0);
        pulse_req();
        wait_to(l + FR);
        #1;
        chk("t1_ready_in_stop", tx_ready, 0);
        tick();
        #1;
        chk("t1_ready_back", tx_ready, 1);

        // back-to-back frames with tx_req held
        tick();
        l  = cyc;
        l2 = l + FR + 1;
        push_frame(l, 0);
        push_frame(l2, 0);
        tx_req = 1'b1;
        wait_to(l2 + 5);
        tx_req = 1'b0;
        wait_to(l2 + FR);
        tick();
        #1;
        chk("t2_ready_back", tx_ready, 1);

        // abort 35 cycles into DATA: three shifts, no done
        tick();
        l = cyc;
        a = l + C + 1 + 3 * C + C / 2;
        push(l, K_LOAD, 1);
        push(l + 1, K_LSEL, 1);
        push(l + 1 + C, K_LSEL, 2);
        for (int k = 0; k < 3; k++)
            push(l + C * (k + 2), K_SHIFT, 1);
        push(a, K_LSEL, 0);
        pulse_req();
        wait_to(a);
        tx_abort = 1'b1;
        #1;
        chk("abort_lsel", line_sel, 0);
        chk("abort_shift", shift_sr, 0);
        chk("abort_ready", tx_ready, 0);
        tick();
        tx_abort = 1'b0;
        #1;
        chk("abort_idle_ready", tx_ready, 1);

        // abort in last stop cycle suppresses tx_done
        tick();
        l = cyc;
        push_frame(l, 1);
        pulse_req();
        wait_to(l + FR);
        tx_abort = 1'b1;
        #1;
        chk("abort_stop_done", tx_done, 0);
        tick();
        tx_abort = 1'b0;
        #1;
        chk("abort_stop_ready", tx_ready, 1);

        // abort and req together in IDLE
        tick();
        tx_req   = 1'b1;
        tx_abort = 1'b1;
        #1;
        chk("idle_abort_ready", tx_ready, 0);
        chk("idle_abort_load", load_sr, 0);
        tick();
        #1;
        chk("idle_abort_ready2", tx_ready, 0);
        chk("idle_abort_lsel", line_sel, 0);
        tick();
        tx_req   = 1'b0;
        tx_abort = 1'b0;
        #1;
        chk("idle_abort_after", tx_ready, 1);

        // reset mid-DATA, then a clean frame
        tick();
        l = cyc;
        r = l + 5 * C;
        push(l, K_LOAD, 1);
        push(l + 1, K_LSEL, 1);
        push(l + 1 + C, K_LSEL, 2);
        for (int k = 0; k < 3; k++)
            push(l + C * (k + 2), K_SHIFT, 1);
        push(r, K_LSEL, 0);
        pulse_req();
        wait_to(r);
        rst = 1'b1;
        #1;
        chk("midrst_lsel", line_sel, 0);
        chk("midrst_shift", shift_sr, 0);
        chk("midrst_done", tx_done, 0);
        chk("midrst_ready", tx_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", tx_ready, 1);
        tick();
        l = cyc;
        push_frame(l, 0);
        pulse_req();
        wait_to(l + FR);
        tick();
        #1;
        chk("midrst_frame_ready", tx_ready, 1);

        repeat (3) tick();
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing: got nothing, required %s=%0d at cycle %0d",
                     kname(e.kind), e.val, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
